// File: rtl/param_fifo_if.sv
// param_fifo_if: handshake/data bundle between a producer/consumer and param_fifo.
//   master : drives flush, clr_err, write, read, inputBus; observes data and status
//   slave  : the FIFO side, drives outputBus and all status outputs
// Parameters: DATA_WIDTH (word width), ADDR_WIDTH (pointer width, depth = 2**ADDR_WIDTH).
interface param_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  clr_err;
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] inputBus;
  logic [DATA_WIDTH-1:0] outputBus;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, write, read, inputBus,
    input  outputBus, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, write, read, inputBus,
    output outputBus, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: parametrised synchronous FIFO with register-array storage.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : param_fifo_if.slave -- flush/clr_err/write/read/inputBus in,
//           outputBus, empty/full, almost_empty/almost_full, count, sticky overflow/underflow out
// Status flags decode combinationally from the registered occupancy count.
// Optional build macro PARAM_FIFO_FWFT_EN: first-word-fall-through output
// (head word shown combinationally); otherwise outputBus is registered with one-cycle latency.
module param_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input logic           clk,
  input logic           reset,
  param_fifo_if.slave   bus
);

  localparam int unsigned         Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0] AfCnt    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AeCnt    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, full;
  logic                  rd_acc, wr_acc;
  logic                  rd_en, wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  // A read frees a slot in the same edge, so a full FIFO still takes a paired write.
  assign rd_acc = bus.read & ~empty;
  assign wr_acc = bus.write & (~full | rd_acc);

  // Flush swallows any access in its cycle.
  assign rd_en = rd_acc & ~bus.flush;
  assign wr_en = wr_acc & ~bus.flush;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
        default: count_d = count_q;
      endcase
      // Set beats clear when an error lands in the same cycle as clr_err.
      overflow_d  = (overflow_q & ~bus.clr_err) | (bus.write & ~wr_acc);
      underflow_d = (underflow_q & ~bus.clr_err) | (bus.read & ~rd_acc);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.inputBus;
  end

`ifdef PARAM_FIFO_FWFT_EN
  // Head word is always on the bus; undefined content while empty.
  assign bus.outputBus = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_en) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign bus.outputBus = dout_q;
`endif

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= AeCnt);
  assign bus.almost_full  = (count_q >= AfCnt);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: randomized scoreboard bench for param_fifo (default geometry 16 x 8).
// The driver keeps a queue-based reference FIFO and pushes one expected snapshot per
// clock edge; the monitor pops and compares on the falling edge.
module tb_param_fifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  param_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] out;
    bit         out_vld;
    int         cnt;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] mout;
  bit         movf;
  bit         munf;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: compares DUT outputs against the next queued snapshot.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        if (mon_e.out_vld) check("outputBus", 32'(bus.outputBus), 32'(mon_e.out));
        check("count",        32'(bus.count),        32'(mon_e.cnt));
        check("empty",        32'(bus.empty),        32'(mon_e.cnt == 0));
        check("full",         32'(bus.full),         32'(mon_e.cnt == D));
        check("almost_empty", 32'(bus.almost_empty), 32'(mon_e.cnt <= AE));
        check("almost_full",  32'(bus.almost_full),  32'(mon_e.cnt >= AF));
        check("overflow",     32'(bus.overflow),     32'(mon_e.ovf));
        check("underflow",    32'(bus.underflow),    32'(mon_e.unf));
      end
    end
  end

  task automatic step(input bit wr, input bit rd, input logic [7:0] din,
                      input bit fl, input bit ce);
    exp_t e;
    bit   rok;
    bit   wok;
    @(negedge clk);
    bus.write    = wr;
    bus.read     = rd;
    bus.inputBus = din;
    bus.flush    = fl;
    bus.clr_err  = ce;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      rok = rd && (mq.size() > 0);
      wok = wr && ((mq.size() < D) || rok);
      if (rok) mout = mq.pop_front();
      if (wok) mq.push_back(din);
      movf = (movf && !ce) || (wr && !wok);
      munf = (munf && !ce) || (rd && !rok);
    end
    e.cnt = mq.size();
    e.ovf = movf;
    e.unf = munf;
`ifdef PARAM_FIFO_FWFT_EN
    e.out_vld = (mq.size() > 0);
    e.out     = (mq.size() > 0) ? mq[0] : 8'h00;
`else
    e.out_vld = 1'b1;
    e.out     = mout;
`endif
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state();
    check("rst_count",     32'(bus.count),        32'd0);
    check("rst_empty",     32'(bus.empty),        32'd1);
    check("rst_full",      32'(bus.full),         32'd0);
    check("rst_almost_e",  32'(bus.almost_empty), 32'd1);
    check("rst_almost_f",  32'(bus.almost_full),  32'd0);
    check("rst_overflow",  32'(bus.overflow),     32'd0);
    check("rst_underflow", 32'(bus.underflow),    32'd0);
`ifndef PARAM_FIFO_FWFT_EN
    check("rst_outputBus", 32'(bus.outputBus),    32'd0);
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    mout = 8'h00;
    movf = 1'b0;
    munf = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  // Hard stop if something wedges the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pushed;
    int  iter;
    bit  w;
    bit  r;

    reset        = 1'b0;
    bus.write    = 1'b0;
    bus.read     = 1'b0;
    bus.flush    = 1'b0;
    bus.clr_err  = 1'b0;
    bus.inputBus = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Ordered fill then drain: thresholds at 14 and 2, full at 16.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    drain(D);

    // Overflow at full, underflow at empty, then clear.
    fill_random(D);
    step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    drain(D);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous access at full and at empty.
    fill_random(D);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    drain(D);
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // 40 words through a random interleave, forcing pointer wrap.
    pushed = 0;
    iter   = 0;
    while ((pushed < 40 || mq.size() > 0) && iter < 2000) begin
      w = (pushed < 40) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      if (w && ((mq.size() < D) || (r && mq.size() > 0))) pushed++;
      step(w, r, 8'($urandom), 1'b0, 1'b0);
      iter++;
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Flush at count 7 with a write pending; then flush clearing a sticky error.
    fill_random(7);
    step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    fill_random(3);
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    drain(2);

    // Fully random traffic including rare flush and clr_err.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), 8'($urandom),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset between clock edges.
    fill_random(5);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_state();
    bus.write = 1'b0;
    bus.read  = 1'b0;
    bus.flush = 1'b0;
    bus.clr_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fill_random(4);
    drain(5);

    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous FIFO and successor to the fixed 32x4 FIFO.
- Storage is an internal register array of 2**ADDR_WIDTH words, so the block does not depend on the ram32x4 IP.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Drop-in buffer between producer/consumer blocks in the lab datapaths.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, pointer width; depth D = 2**ADDR_WIDTH (default 16).
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (legal range 1..D).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (legal range 0..D-1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous clear of contents and error flags.
- clr_err  in  1  synchronous clear of overflow/underflow only.
- write  in  1  push request.
- read  in  1  pop request.
- inputBus  in  DATA_WIDTH  write data.
- outputBus  out  DATA_WIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == D.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..D.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - rd_ptr, wr_ptr and count are cleared to 0.
  - outputBus=0, overflow=0, underflow=0.
  - Flags follow from count: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not cleared.
- Reset removal must be clean with respect to clk; the first active edge after deassertion operates normally.
- Internal acceptance signals:
  - rd_acc = read & ~empty.
  - wr_acc = write & (~full | rd_acc).
  - When full, a simultaneous read+write is accepted for both; count stays at D.
  - When empty, a read is rejected even if a write arrives in the same cycle; the write is accepted and count becomes 1.
- On wr_acc: mem[wr_ptr] <= inputBus; wr_ptr <= wr_ptr+1, wrapping modulo D.
- On rd_acc: rd_ptr <= rd_ptr+1, wrapping modulo D.
- Count update: count <= count + wr_acc - rd_acc. Count is a register; all four status flags decode combinationally from it, so they reflect the post-edge state.
- Read latency (default mode): outputBus <= mem[rd_ptr] on the edge where rd_acc=1, so data is valid the cycle after read. outputBus holds its value on all other cycles, including rejected reads.
- Error flags:
  - overflow <= 1 when write & ~wr_acc.
  - underflow <= 1 when read & ~rd_acc.
  - Both are sticky until clr_err, flush or reset.
- flush=1 at an edge:
  - Pointers, count, overflow and underflow are cleared to 0.
  - Any read or write in that cycle is ignored and does not set error flags.
  - outputBus holds its value.
  - flush has priority over clr_err.
- clr_err=1 clears both error flags. If an error event occurs in the same cycle, set wins.
- Pointer wrap: after D writes and D reads, the pointers return to 0 with no data corruption.

Optional Feature:
- Macro: PARAM_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - outputBus = mem[rd_ptr] combinationally whenever empty=0, so the head word is visible before read.
  - read pops the head; outputBus shows the next word in the same cycle as the pointer advances.
  - outputBus value is don't-care while empty=1.
  - A write into an empty FIFO is visible on outputBus the cycle after the write edge.
- Undefined: registered one-cycle read latency as specified in Behaviour.

Test Plan:
- Reset then idle: drive reset=0, release, hold 3 cycles -> empty=1, almost_empty=1, full=0, count=0, outputBus=0, overflow=0, underflow=0.
- Fill/drain: write 0x00..0x0F (16 words) -> full=1 and count=16 after the 16th write, almost_full rises at count=14. Then 16 reads -> outputBus shows 0x00..0x0F in order, each one cycle after its read; empty=1 at the end; almost_empty rises at count=2.
- Overflow/underflow: at full, write 0xAA alone -> count stays 16, overflow=1, the contents are unchanged. Drain, then read on empty -> underflow=1, outputBus holds last value 0x0F. Pulse clr_err -> both flags 0.
- Simultaneous access: at full, read+write 0x55 -> count=16, the oldest word is output. At empty, read+write 0x33 -> count=1, underflow=1, and the next read returns 0x33.
- Wrap and flush: push/pop 40 words in a random interleave -> the output sequence equals the input sequence. Mid-stream with count=7, assert flush with write=1 -> count=0, empty=1, the write is discarded, overflow stays 0.
- FWFT build: write 0x11 and 0x22 -> outputBus=0x11 the cycle after the first write with no read. Read -> outputBus=0x22 immediately after that edge.
